// File: rtl/axi_write_arbiter.sv
// axi_write_arbiter: round-robin sharing of one AXI4 write channel among
// N_REQ single-beat write requesters. One transaction is outstanding at a
// time; the write response is returned to the requester that won it.
module axi_write_arbiter #(
  parameter int N_REQ          = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 128
) (
  input  logic                              s_axi_aclk,
  input  logic                              s_axi_aresetn,
  input  logic [N_REQ-1:0]                  req_valid,
  output logic [N_REQ-1:0]                  req_ready,
  input  logic [N_REQ*AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*AXI_DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]                  done,
  output logic [1:0]                        done_resp,
  output logic [15:0]                       err_count,
  output logic                              busy,
  output logic [AXI_ADDR_WIDTH-1:0]         m_axi_awaddr,
  output logic [15:0]                       m_axi_awid,
  output logic [7:0]                        m_axi_awlen,
  output logic [2:0]                        m_axi_awsize,
  output logic [1:0]                        m_axi_awburst,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]         m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]       m_axi_wstrb,
  output logic                              m_axi_wlast,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic [15:0]                       m_axi_bid,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                    state_r;
  logic [IDX_W-1:0]          rr_ptr_r;
  logic [IDX_W-1:0]          gnt_idx_r;
  logic [AXI_ADDR_WIDTH-1:0] addr_r;
  logic [AXI_DATA_WIDTH-1:0] data_r;
  logic                      awvalid_r;
  logic                      wvalid_r;
  logic                      bready_r;
  logic [N_REQ-1:0]          done_r;
  logic [1:0]                done_resp_r;
  logic [15:0]               err_count_r;
  logic                      busy_r;

  logic                      win_found_s;
  logic [IDX_W-1:0]          win_idx_s;
  logic [N_REQ-1:0]          win_oh_s;
  logic [N_REQ-1:0]          owner_oh_s;
  logic [15:0]               owner_id_s;
  logic                      aw_ok_s;
  logic                      w_ok_s;
  logic                      err_hit_s;
  logic [15:0]               err_next_s;

  // Requester index base+off, wrapping at N_REQ (both operands below N_REQ).
  function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
    int sum;
    sum = base + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end else begin
      sum = sum;
    end
    return sum[IDX_W-1:0];
  endfunction

  // Round-robin search: first pending requester at or after rr_ptr_r.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found_s && req_valid[wrap_idx(int'(rr_ptr_r), k)]) begin
        win_found_s = 1'b1;
        win_idx_s   = wrap_idx(int'(rr_ptr_r), k);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // One-hot forms of the current winner and of the transaction owner.
  always_comb begin
    win_oh_s               = '0;
    owner_oh_s             = '0;
    win_oh_s[win_idx_s]    = 1'b1;
    owner_oh_s[gnt_idx_r]  = 1'b1;
  end

  // Same-cycle acceptance for the winner; masked while reset is applied.
  always_comb begin
    if (s_axi_aresetn && (state_r == IDLE) && win_found_s) begin
      req_ready = win_oh_s;
    end else begin
      req_ready = '0;
    end
  end

  assign owner_id_s = {{(16 - IDX_W){1'b0}}, gnt_idx_r};
  assign aw_ok_s    = !awvalid_r || m_axi_awready;
  assign w_ok_s     = !wvalid_r || m_axi_wready;
  assign err_hit_s  = (m_axi_bresp != 2'b00) || (m_axi_bid != owner_id_s);

  // Saturating error counter update, evaluated on the response handshake.
  always_comb begin
    if ((state_r == RESP) && m_axi_bvalid && err_hit_s && (err_count_r != 16'hFFFF)) begin
      err_next_s = err_count_r + 16'd1;
    end else begin
      err_next_s = err_count_r;
    end
  end

  // Transaction FSM with registered channel controls and completion pulse.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      gnt_idx_r   <= '0;
      addr_r      <= '0;
      data_r      <= '0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      done_r      <= '0;
      done_resp_r <= 2'b00;
      err_count_r <= 16'h0000;
      busy_r      <= 1'b0;
    end else begin
      done_r      <= '0;
      done_resp_r <= 2'b00;
      err_count_r <= err_next_s;
      case (state_r)
        IDLE: begin
          if (win_found_s) begin
            addr_r    <= req_addr[win_idx_s*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            data_r    <= req_data[win_idx_s*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            gnt_idx_r <= win_idx_s;
            rr_ptr_r  <= wrap_idx(int'(win_idx_s), 1);
            awvalid_r <= 1'b1;
            wvalid_r  <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= XFER;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        XFER: begin
          // Each channel retires on its own handshake; RESP once both have.
          if (m_axi_awready) begin
            awvalid_r <= 1'b0;
          end
          if (m_axi_wready) begin
            wvalid_r <= 1'b0;
          end
          if (aw_ok_s && w_ok_s) begin
            bready_r <= 1'b1;
            state_r  <= RESP;
          end
        end
        RESP: begin
          if (m_axi_bvalid) begin
            bready_r    <= 1'b0;
            done_r      <= owner_oh_s;
            done_resp_r <= m_axi_bresp;
            state_r     <= IDLE;
          end
        end
        default: begin
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign done          = done_r;
  assign done_resp     = done_resp_r;
  assign err_count     = err_count_r;
  assign busy          = busy_r;
  assign m_axi_awaddr  = addr_r;
  assign m_axi_awid    = owner_id_s;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'd4;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = awvalid_r;
  assign m_axi_wdata   = data_r;
  assign m_axi_wstrb   = {STRB_W{1'b1}};
  assign m_axi_wlast   = wvalid_r;
  assign m_axi_wvalid  = wvalid_r;
  assign m_axi_bready  = bready_r;

endmodule

// File: doc/axi_write_arbiter.md
# axi_write_arbiter

Shares one AXI4 write channel among `N_REQ` independent requesters, each of which issues single-beat 128-bit register/memory writes. A round-robin scheduler accepts one request at a time and drives the AW, W and B phases into the downstream AXI4 slave port. It then returns the write response to the winning requester. It sits between the control-plane write sources and the 128-bit AXI4 slave port of the datapath.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `AXI_ADDR_WIDTH`, 32: address width.
- `AXI_DATA_WIDTH`, 128: data width; strobe width is `AXI_DATA_WIDTH/8`.
- `s_axi_aclk`  in  1  single clock; all logic is on its rising edge.
- `s_axi_aresetn`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  N_REQ  per-requester write request.
- `req_ready`  out  N_REQ  one-hot acceptance of a request.
- `req_addr`  in  N_REQ*AXI_ADDR_WIDTH  packed addresses; requester i occupies slice i.
- `req_data`  in  N_REQ*AXI_DATA_WIDTH  packed write data.
- `done`  out  N_REQ  one-cycle completion pulse for the owning requester.
- `done_resp`  out  2  BRESP of the completed write; valid while `done` is nonzero.
- `err_count`  out  16  saturating count of responses other than OKAY and of BID mismatches.
- `busy`  out  1  high whenever the state is not IDLE.
- `m_axi_awaddr`  out  AXI_ADDR_WIDTH; `m_axi_awid`  out  16; `m_axi_awlen`  out  8; `m_axi_awsize`  out  3; `m_axi_awburst`  out  2; `m_axi_awvalid`  out  1; `m_axi_awready`  in  1.
- `m_axi_wdata`  out  AXI_DATA_WIDTH; `m_axi_wstrb`  out  AXI_DATA_WIDTH/8; `m_axi_wlast`  out  1; `m_axi_wvalid`  out  1; `m_axi_wready`  in  1.
- `m_axi_bresp`  in  2; `m_axi_bid`  in  16; `m_axi_bvalid`  in  1; `m_axi_bready`  out  1.

## Operation
- FSM states are IDLE, XFER and RESP.
- **IDLE:** round-robin arbitration over `req_valid`. The search starts at pointer `rr_ptr` (reset 0) and takes the first set bit, wrapping from N_REQ-1 to 0.
  - `req_ready[g]` is asserted combinationally in IDLE for the winner g only, so acceptance happens in the same cycle.
  - On acceptance, latch addr, data and g into registers; set `rr_ptr` to (g+1) mod N_REQ; go to XFER.
- **XFER:** `awvalid` and `wvalid` rise together.
  - Each channel drops independently in the cycle after its own handshake (`valid & ready`).
  - When both handshakes have completed (in the same cycle or different cycles), go to RESP.
- **RESP:** `bready` = 1.
  - On `bvalid`: pulse `done[g]` and drive `done_resp` = `bresp` in the next cycle, then return to IDLE.
  - If `bresp` is not 2'b00, or `bid` differs from the latched g, increment `err_count`. The count saturates at 16'hFFFF.
- **Constant fields:**
  - `awlen` = 0, `awsize` = 3'd4 (16 bytes), `awburst` = 2'b01 (INCR), `wlast` = 1 whenever `wvalid` is high.
  - `wstrb` = all ones.
  - `awid` = g zero-extended to 16 bits.
- Only one transaction is outstanding at any time; no new request is accepted until `done` has fired.
- Payload registers hold stable from acceptance until the respective handshake (AXI stability rule).
- Requests that are not selected remain pending with no timeout. A requester may drop `req_valid` before acceptance without consequence.

## Timing
- **Reset values:** all outputs are 0, except `awsize` = 4, `awburst` = 1 and `wstrb` = all ones. State = IDLE, `rr_ptr` = 0, `err_count` = 0.
- **Assertion of reset mid-transaction:**
  - All valids, `bready`, `done` and `busy` clear immediately (asynchronously).
  - No `done` pulse is produced for the aborted write.
  - `err_count` is cleared.
- **Best-case latency, with the slave ready throughout:**
  - Accept at cycle T.
  - AW and W handshakes at T+1.
  - `bready` high at T+2; `bvalid` at T+2.
  - `done` at T+3.
  - The next acceptance is possible at T+3, giving 3 cycles per write.
- `busy` is high from T+1 through the `done` cycle inclusive.
- A single continuously asserted requester is served every 3 cycles. With all requesters active, the grant order is 0,1,2,3,0,… .
- `bvalid` arriving while the state is XFER is ignored (`bready` = 0 there). It is sampled once the FSM reaches RESP.

## Test plan
- **Single write, slave always ready:** requester 2 writes addr 0x40, data 0x0123…CDEF, slave returns bresp 0.
  - Expect `awid` = 2, `awaddr` = 0x40, `wlast` = 1.
  - Expect `done` = 4'b0100 and `done_resp` = 0 at T+3; `err_count` = 0.
- **Fairness:** all four requesters hold `req_valid` continuously for 8 writes.
  - Expect grants in order 0,1,2,3,0,1,2,3.
  - Expect exactly one `req_ready` bit per acceptance and 3 cycles between acceptances.
- **Skewed handshakes:** `awready` delayed 5 cycles and `wready` delayed 2 cycles.
  - Expect `wvalid` to drop one cycle after its handshake while `awvalid` stays high.
  - Expect RESP to be entered only after the AW handshake; `awaddr` and `wdata` stable throughout.
- **Error accounting:**
  - bresp = 2'b10 gives `done_resp` = 2 and `err_count` = 1.
  - A following write with bid ≠ awid gives `err_count` = 2.
  - Preloading 16'hFFFF plus a further error leaves the count at 16'hFFFF.
- **Reset mid-operation:** deassert `s_axi_aresetn` while in RESP.
  - Expect `bready`, `busy` and `done` to go to 0 immediately, with no `done` pulse.
  - After release, requester 0 is granted first (`rr_ptr` = 0).
